trs_timing_decoder: RTL and testbench

- Upstream stage of the line-alignment block; sits directly on the incoming background video path.
- Extracts embedded timing from 20-bit 4:2:2 video: luma in [19:10], chroma in [9:0]. The timing reference sequence (TRS) on luma is 3FF, 000, 000, XYZ.
- Regenerates {F,V,H} flags, a horizontal blanking strobe and a delay-matched data stream.
- Measures active pixels per line and line count, and reports lock status and TRS protection errors.

---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/trs_timing_decoder_if.sv | 36 +++
 rtl/trs_detect.sv | 60 ++++++
 rtl/trs_timing_decoder.sv | 177 +++++++++++++++++
 tb/tb_trs_timing_decoder.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the embedded-timing (TRS) path.
// Holds the TRS word constants, XYZ bit positions within a 10-bit luma
// word, the lock state encoding and the XYZ protection function.
package video_timing_pkg;

  localparam logic [9:0] TRS_WORD_3FF = 10'h3FF;
  localparam logic [9:0] TRS_WORD_000 = 10'h000;

  // Bit positions inside a 10-bit XYZ word
  localparam int XYZ_F_BIT   = 8;
  localparam int XYZ_V_BIT   = 7;
  localparam int XYZ_H_BIT   = 6;
  localparam int XYZ_P_MSB   = 5;
  localparam int XYZ_P_LSB   = 2;

  // Luma occupies the upper half of a 20-bit {luma, chroma} word
  localparam int LUMA_LSB    = 10;

  // Lock state encoding
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef struct packed {
    logic f;
    logic v;
    logic h;
  } hvf_t;

  // Protection bits P3..P0 carried in XYZ[5:2]
  function automatic logic [3:0] xyz_protect(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/trs_timing_decoder_if.sv
// Video-side bundle of the TRS timing decoder.
//   data_in        : incoming {luma, chroma} word
//   data_out       : data_in delayed by 5 clocks
//   hvf_out        : {F,V,H} aligned to data_out
//   hblanking_out  : copy of hvf_out[0]
//   number_active  : active words of the last complete line
//   line_count     : line number within the frame
//   locked         : lock status
//   trs_error      : one-clock pulse on a rejected XYZ word
//   error_count    : saturating rejected-XYZ count
// master = video source / observer, slave = decoder.
interface trs_timing_decoder_if;

  logic [19:0] data_in;
  logic [19:0] data_out;
  logic [2:0]  hvf_out;
  logic        hblanking_out;
  logic [11:0] number_active;
  logic [10:0] line_count;
  logic        locked;
  logic        trs_error;
  logic [7:0]  error_count;

  modport master (
    output data_in,
    input  data_out, hvf_out, hblanking_out, number_active,
    input  line_count, locked, trs_error, error_count
  );

  modport slave (
    input  data_in,
    output data_out, hvf_out, hblanking_out, number_active,
    output line_count, locked, trs_error, error_count
  );

endinterface

// File: rtl/trs_detect.sv
// TRS preamble detector and XYZ decoder.
// Keeps a 4-deep shift register of incoming words (s0 newest) and flags a
// TRS when luma reads 3FF, 000, 000, XYZ across s3..s0.
//   clk, reset : video clock, async active-high reset
//   data_in    : incoming {luma, chroma} word
//   s3_word    : oldest shift-register word, feeds the output register
//   trs_valid  : accepted TRS present in s3..s0
//   trs_bad    : TRS present but XYZ protection rejected
//   f, v, h    : flags decoded from the XYZ word in s0
module trs_detect
  import video_timing_pkg::*;
#(
  parameter int CHECK_PROTECTION = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] data_in,
  output logic [19:0] s3_word,
  output logic        trs_valid,
  output logic        trs_bad,
  output logic        f,
  output logic        v,
  output logic        h
);

  logic [19:0] s0, s1, s2, s3;
  logic        preamble;
  logic        prot_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s0 <= data_in;
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Only luma is examined; 3FF/000 on chroma never forms a preamble.
  assign preamble = (s3[19:LUMA_LSB] == TRS_WORD_3FF) &&
                    (s2[19:LUMA_LSB] == TRS_WORD_000) &&
                    (s1[19:LUMA_LSB] == TRS_WORD_000) &&
                    s0[19];

  assign f = s0[LUMA_LSB + XYZ_F_BIT];
  assign v = s0[LUMA_LSB + XYZ_V_BIT];
  assign h = s0[LUMA_LSB + XYZ_H_BIT];

  assign prot_ok = (s0[LUMA_LSB + XYZ_P_MSB : LUMA_LSB + XYZ_P_LSB] == xyz_protect(f, v, h));

  assign trs_bad   = preamble && !prot_ok && (CHECK_PROTECTION != 0);
  assign trs_valid = preamble && !trs_bad;
  assign s3_word   = s3;

endmodule

// File: rtl/trs_timing_decoder.sv
// TRS timing decoder: regenerates {F,V,H} and H blanking from embedded
// timing, delay-matches the video, measures active words per line and line
// number, and tracks lock.
//   clk, reset : video clock, async active-high reset
//   vid        : video bundle (slave side), see trs_timing_decoder_if
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SEARCH | not locked, waiting for the first valid SAV
// ST_VERIFY | counting consecutive lines with equal active length
// ST_LOCKED | line length stable; locked output high
module trs_timing_decoder
  import video_timing_pkg::*;
#(
  parameter int CHECK_PROTECTION = 1,
  parameter int LOCK_LINES       = 4,
  parameter int WATCHDOG_CLKS    = 4400
) (
  input  logic                 clk,
  input  logic                 reset,
  trs_timing_decoder_if.slave  vid
);

  localparam logic [12:0] WD_LAST   = 13'(WATCHDOG_CLKS - 1);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_LINES - 1);

  logic [19:0] s3_word;
  logic        trs_valid, trs_bad;
  logic        f, v, h;

  trs_detect #(.CHECK_PROTECTION(CHECK_PROTECTION)) u_trs_detect (
    .clk       (clk),
    .reset     (reset),
    .data_in   (vid.data_in),
    .s3_word   (s3_word),
    .trs_valid (trs_valid),
    .trs_bad   (trs_bad),
    .f         (f),
    .v         (v),
    .h         (h)
  );

  logic [19:0] data_out_q;
  hvf_t        hvf_q, hvf_dec, hvf_d;
  logic [11:0] act_cnt_q, act_inc, number_active_q;
  logic [10:0] line_cnt_q;
  logic        prev_f_q;
  logic        trs_error_q;
  logic [7:0]  err_cnt_q;
  logic [12:0] wd_cnt_q;
  logic        wd_expire;
  logic [1:0]  state_q, state_d;
  logic [7:0]  match_q, match_d;
  logic        eav_valid, sav_valid, h_rise;

  assign hvf_dec   = {f, v, h};
  assign hvf_d     = trs_valid ? hvf_dec : hvf_q;
  assign eav_valid = trs_valid && h;
  assign sav_valid = trs_valid && !h;

  // hvf_out[0] goes 0->1 on this edge: end of the active region
  assign h_rise    = eav_valid && !hvf_q.h;

  assign act_inc   = (act_cnt_q == 12'hFFF) ? act_cnt_q : act_cnt_q + 12'd1;

  // Fires on the edge at which the counter would reach WATCHDOG_CLKS
  assign wd_expire = !trs_valid && (wd_cnt_q >= WD_LAST);

  // Flags change on the same edge data_out takes the TRS 3FF word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
      hvf_q      <= 3'b001;
    end else begin
      data_out_q <= s3_word;
      hvf_q      <= hvf_d;
    end
  end

  // Active count includes the word on data_out at the latching edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_cnt_q       <= '0;
      number_active_q <= '0;
    end else if (h_rise) begin
      number_active_q <= act_inc;
      act_cnt_q       <= '0;
    end else if (!hvf_q.h) begin
      act_cnt_q       <= act_inc;
    end
  end

  // F falling between consecutive EAVs marks the start of field 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt_q <= '0;
      prev_f_q   <= 1'b0;
    end else if (eav_valid) begin
      prev_f_q <= f;
      if ((f != prev_f_q) && !f)
        line_cnt_q <= '0;
      else
        line_cnt_q <= line_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trs_error_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      trs_error_q <= trs_bad;
      if (trs_bad && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wd_cnt_q <= '0;
    else if (trs_valid)
      wd_cnt_q <= '0;
    else if (wd_cnt_q != 13'h1FFF)
      wd_cnt_q <= wd_cnt_q + 13'd1;
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    case (state_q)
      ST_SEARCH: begin
        if (sav_valid) begin
          state_d = ST_VERIFY;
          match_d = '0;
        end
      end
      ST_VERIFY: begin
        if (trs_bad || wd_expire) begin
          state_d = ST_SEARCH;
        end else if (h_rise) begin
          if (act_inc == number_active_q) begin
            match_d = match_q + 8'd1;
            if (match_q == LOCK_LAST)
              state_d = ST_LOCKED;
          end else begin
            match_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (trs_bad || wd_expire || (h_rise && (act_inc != number_active_q)))
          state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  assign vid.data_out      = data_out_q;
  assign vid.hvf_out       = hvf_q;
  assign vid.hblanking_out = hvf_q.h;
  assign vid.number_active = number_active_q;
  assign vid.line_count    = line_cnt_q;
  assign vid.locked        = (state_q == ST_LOCKED);
  assign vid.trs_error     = trs_error_q;
  assign vid.error_count   = err_cnt_q;

endmodule

// File: tb/tb_trs_timing_decoder.sv
// Directed bench for trs_timing_decoder. Two decoders share one input
// stream: dut_p rejects bad XYZ words, dut_np has protection checking off.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_trs_timing_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trs_timing_decoder_if vid_p ();
  trs_timing_decoder_if vid_np ();

  trs_timing_decoder #(.CHECK_PROTECTION(1), .LOCK_LINES(4), .WATCHDOG_CLKS(4400)) dut_p (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_p.slave)
  );

  trs_timing_decoder #(.CHECK_PROTECTION(0), .LOCK_LINES(4), .WATCHDOG_CLKS(4400)) dut_np (
    .clk   (clk),
    .reset (reset),
    .vid   (vid_np.slave)
  );

  localparam logic [19:0] BLANK  = {10'h040, 10'h200};
  localparam logic [19:0] STOPW  = {10'h200, 10'h200};

  int errors = 0;
  int checks = 0;
  int exp_lc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic put(input logic [19:0] w);
    @(negedge clk);
    vid_p.data_in  = w;
    vid_np.data_in = w;
  endtask

  // Chroma walks 3FF,000,000 so a chroma-based detector would false-trigger
  function automatic logic [19:0] act_word(input int i);
    return {10'h1A5, ((i % 3) == 0) ? 10'h3FF : 10'h000};
  endfunction

  task automatic trs(input logic [9:0] xyz);
    put({10'h3FF, 10'h3FF});
    put(20'h0);
    put(20'h0);
    put({xyz, xyz});
  endtask

  task automatic h1(input logic [9:0] xyz, input int len);
    trs(xyz);
    repeat (len - 4) put(BLANK);
  endtask

  task automatic h0(input logic [9:0] xyz, input int len);
    trs(xyz);
    for (int i = 0; i < len - 4; i++) put(act_word(i));
  endtask

  initial begin
    reset = 1'b1;
    vid_p.data_in  = '0;
    vid_np.data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_hvf",    32'(vid_p.hvf_out), 32'h1);
    chk("rst_hblank", 32'(vid_p.hblanking_out), 32'h1);
    chk("rst_dout",   32'(vid_p.data_out), 32'h0);
    chk("rst_locked", 32'(vid_p.locked), 32'h0);
    chk("rst_na",     32'(vid_p.number_active), 32'h0);
    chk("rst_lc",     32'(vid_p.line_count), 32'h0);
    reset = 1'b0;
    repeat (10) put(20'h0);

    // First EAV (F0 V0 H1): 3FF reaches data_out 5 clocks after it is driven
    trs(10'h274);
    put(BLANK);
    chk("eav_dout_pre", 32'(vid_p.data_out), 32'h0);
    put(BLANK);
    chk("eav_dout_3ff", 32'(vid_p.data_out), 32'hFFFFF);
    chk("eav_hvf",      32'(vid_p.hvf_out), 32'h1);
    repeat (274) put(BLANK);
    exp_lc = 1;
    chk("eav_lc", 32'(vid_p.line_count), 32'(exp_lc));

    // First SAV: flags drop together with the SAV 3FF on data_out
    trs(10'h200);
    put(act_word(0));
    chk("sav_hvf_pre", 32'(vid_p.hvf_out), 32'h1);
    put(act_word(1));
    chk("sav_hvf",     32'(vid_p.hvf_out), 32'h0);
    chk("sav_hblank",  32'(vid_p.hblanking_out), 32'h0);
    chk("sav_dout",    32'(vid_p.data_out), 32'hFFFFF);
    for (int i = 2; i < 1916; i++) put(act_word(i));

    // Five 1920-word active regions; lock on the fifth latch
    for (int k = 1; k <= 5; k++) begin
      h1(10'h274, 280);
      exp_lc++;
      chk("line_na",     32'(vid_p.number_active), 32'd1920);
      chk("line_locked", 32'(vid_p.locked), 32'(k == 5));
      h0(10'h200, 1920);
    end
    chk("line_lc", 32'(vid_p.line_count), 32'(exp_lc));

    h1(10'h274, 280);
    exp_lc++;
    chk("lock_hold", 32'(vid_p.locked), 32'h1);

    // One short line drops lock; four equal short lines relock
    h0(10'h200, 1919);
    h1(10'h274, 281);
    exp_lc++;
    chk("short_na",     32'(vid_p.number_active), 32'd1919);
    chk("short_unlock", 32'(vid_p.locked), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      h0(10'h200, 1919);
      h1(10'h274, 281);
      exp_lc++;
      chk("relock", 32'(vid_p.locked), 32'(j == 4));
    end
    chk("relock_lc", 32'(vid_p.line_count), 32'(exp_lc));

    // EAV with P0 flipped (270h): rejected by dut_p, accepted by dut_np
    h0(10'h200, 1919);
    chk("err_cnt_pre", 32'(vid_p.error_count), 32'h0);
    trs(10'h270);
    put(BLANK);
    chk("bad_err_pre", 32'(vid_p.trs_error), 32'h0);
    put(BLANK);
    chk("bad_err",       32'(vid_p.trs_error), 32'h1);
    chk("bad_err_cnt",   32'(vid_p.error_count), 32'h1);
    chk("bad_hvf",       32'(vid_p.hvf_out), 32'h0);
    chk("bad_unlock",    32'(vid_p.locked), 32'h0);
    chk("np_hvf",        32'(vid_np.hvf_out), 32'h1);
    chk("np_err",        32'(vid_np.trs_error), 32'h0);
    chk("np_locked",     32'(vid_np.locked), 32'h1);
    put(BLANK);
    chk("bad_err_end", 32'(vid_p.trs_error), 32'h0);
    repeat (274) put(BLANK);
    chk("bad_lc", 32'(vid_p.line_count), 32'(exp_lc));

    // Missed EAV stretches the active run to 4119 words: saturates at 4095
    h0(10'h200, 1919);
    h1(10'h274, 281);
    exp_lc++;
    chk("na_sat",     32'(vid_p.number_active), 32'd4095);
    chk("sat_locked", 32'(vid_p.locked), 32'h0);
    chk("np_na",      32'(vid_np.number_active), 32'd1919);
    for (int j = 1; j <= 5; j++) begin
      h0(10'h200, 1919);
      h1(10'h274, 281);
      exp_lc++;
      chk("relock2", 32'(vid_p.locked), 32'(j == 5));
    end

    // Stream stops after an EAV: unlock exactly WATCHDOG_CLKS after it
    h0(10'h200, 1919);
    trs(10'h274);
    exp_lc++;
    repeat (4401) put(STOPW);
    chk("wd_before", 32'(vid_p.locked), 32'h1);
    put(STOPW);
    chk("wd_expire",    32'(vid_p.locked), 32'h0);
    chk("np_wd_expire", 32'(vid_np.locked), 32'h0);
    chk("wd_lc",        32'(vid_p.line_count), 32'(exp_lc));

    // Field change: F 0->1 counts on, F 1->0 restarts at line 0
    h1(10'h368, 100);
    exp_lc++;
    chk("f1_hvf", 32'(vid_p.hvf_out), 32'h5);
    chk("f1_lc",  32'(vid_p.line_count), 32'(exp_lc));
    h0(10'h31C, 100);
    chk("f1_sav_hvf", 32'(vid_p.hvf_out), 32'h4);
    h1(10'h274, 100);
    chk("f0_hvf", 32'(vid_p.hvf_out), 32'h1);
    chk("f0_lc",  32'(vid_p.line_count), 32'h0);
    h1(10'h2D8, 50);
    chk("v1_hvf", 32'(vid_p.hvf_out), 32'h3);
    chk("v1_lc",  32'(vid_p.line_count), 32'h1);

    // Reset mid-line discards everything
    h0(10'h200, 60);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_hvf",  32'(vid_p.hvf_out), 32'h1);
    chk("mid_rst_dout", 32'(vid_p.data_out), 32'h0);
    chk("mid_rst_na",   32'(vid_p.number_active), 32'h0);
    chk("mid_rst_lc",   32'(vid_p.line_count), 32'h0);
    chk("mid_rst_err",  32'(vid_p.error_count), 32'h0);
    chk("mid_rst_lock", 32'(vid_p.locked), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) put(act_word(i));
    h1(10'h274, 280);
    chk("post_rst_na", 32'(vid_p.number_active), 32'h0);
    chk("post_rst_lc", 32'(vid_p.line_count), 32'h1);
    h0(10'h200, 1920);
    h1(10'h274, 280);
    chk("post_rst_na2",   32'(vid_p.number_active), 32'd1920);
    chk("post_rst_lock",  32'(vid_p.locked), 32'h0);
    chk("np_err_cnt_end", 32'(vid_np.error_count), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
